// File: rtl/map_ss_seq_if.sv
// Save-state bus: mapper register access (ss_*) plus byte-buffer access (buf_*).
// The sequencer is the master; the mapper/buffer side is the slave.
interface map_ss_seq_if;
    logic        ss_act;
    logic        ss_we;
    logic [7:0]  ss_addr;
    logic [7:0]  ss_wdat;
    logic [7:0]  ss_rdat;
    logic [15:0] buf_addr;
    logic        buf_we;
    logic [7:0]  buf_wdat;
    logic [7:0]  buf_rdat;

    modport master (
        output ss_act, ss_we, ss_addr, ss_wdat,
        input  ss_rdat,
        output buf_addr, buf_we, buf_wdat,
        input  buf_rdat
    );

    modport slave (
        input  ss_act, ss_we, ss_addr, ss_wdat,
        output ss_rdat,
        input  buf_addr, buf_we, buf_wdat,
        output buf_rdat
    );
endinterface

// File: rtl/map_ss_seq.sv
// Save-state sequencer: copies mapper registers 0..SS_REGS-1 to a byte buffer and back.
// Optional MAP_SS_SUM_EN adds an XOR checksum byte stored at BUF_BASE+SS_REGS.
module map_ss_seq #(
    parameter int          SS_REGS  = 128,
    parameter logic [15:0] BUF_BASE = 16'h0000,
    parameter int          M2_TMO   = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_save,
    input  logic         start_load,
    input  logic         m2_fall,
    output logic         busy,
    output logic         done,
    output logic         err,
    map_ss_seq_if.master bus
);
    localparam int            TW   = (M2_TMO < 2) ? 1 : $clog2(M2_TMO + 1);
    localparam logic [7:0]    LAST = 8'(SS_REGS - 1);
    localparam logic [TW-1:0] TMO  = TW'(M2_TMO);

    typedef enum logic [3:0] {
        IDLE, S_ADDR, S_STORE, L_FETCH, L_WAIT, L_WRITE, L_HOLD, FIN
`ifdef MAP_SS_SUM_EN
        , S_SUM, L_SFETCH, L_SCHK
`endif
    } state_t;

    state_t        state, state_nxt;
    logic [7:0]    idx, idx_nxt;
    logic [TW-1:0] cnt, cnt_nxt;
    logic          busy_nxt, done_nxt, err_nxt;
    logic          act_nxt, we_nxt, bwe_nxt;
    logic [7:0]    addr_nxt, wdat_nxt, bwdat_nxt;
    logic [15:0]   baddr_nxt;
    logic          fin, abort;
`ifdef MAP_SS_SUM_EN
    logic [7:0]    sum, sum_nxt;
`endif

    // Outputs are registered: each branch below sets the values seen while in the next state.
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        act_nxt   = bus.ss_act;
        we_nxt    = bus.ss_we;
        addr_nxt  = bus.ss_addr;
        wdat_nxt  = bus.ss_wdat;
        baddr_nxt = bus.buf_addr;
        bwe_nxt   = 1'b0;
        bwdat_nxt = bus.buf_wdat;
        fin       = 1'b0;
        abort     = 1'b0;
`ifdef MAP_SS_SUM_EN
        sum_nxt   = sum;
`endif
        case (state)
            IDLE: begin
                if (start_save || start_load) begin
                    idx_nxt  = '0;
                    busy_nxt = 1'b1;
                    act_nxt  = 1'b1;
`ifdef MAP_SS_SUM_EN
                    sum_nxt  = '0;
`endif
                    if (start_save) begin
                        state_nxt = S_ADDR;
                        addr_nxt  = '0;
                    end else begin
                        state_nxt = L_FETCH;
                        baddr_nxt = BUF_BASE;
                    end
                end
            end
            S_ADDR: begin
                state_nxt = S_STORE;
                bwe_nxt   = 1'b1;
                bwdat_nxt = bus.ss_rdat;
                baddr_nxt = BUF_BASE + 16'(idx);
`ifdef MAP_SS_SUM_EN
                sum_nxt   = sum ^ bus.ss_rdat;
`endif
            end
            S_STORE: begin
                if (idx == LAST) begin
`ifdef MAP_SS_SUM_EN
                    state_nxt = S_SUM;
                    bwe_nxt   = 1'b1;
                    bwdat_nxt = sum;
                    baddr_nxt = BUF_BASE + 16'(SS_REGS);
`else
                    fin = 1'b1;
`endif
                end else begin
                    idx_nxt   = idx + 8'd1;
                    addr_nxt  = idx + 8'd1;
                    state_nxt = S_ADDR;
                end
            end
            L_FETCH: state_nxt = L_WAIT;
            L_WAIT: begin
                state_nxt = L_WRITE;
                wdat_nxt  = bus.buf_rdat;
                we_nxt    = 1'b1;
                addr_nxt  = idx;
                cnt_nxt   = '0;
`ifdef MAP_SS_SUM_EN
                sum_nxt   = sum ^ bus.buf_rdat;
`endif
            end
            L_WRITE: begin
                // A fall in the first cycle may precede ss_we settling at the mapper, so skip it.
                if (cnt != '0 && m2_fall) begin
                    state_nxt = L_HOLD;
                    we_nxt    = 1'b0;
                end else if (cnt == TMO) begin
                    abort = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            L_HOLD: begin
                if (idx == LAST) begin
`ifdef MAP_SS_SUM_EN
                    state_nxt = L_SFETCH;
                    baddr_nxt = BUF_BASE + 16'(SS_REGS);
`else
                    fin = 1'b1;
`endif
                end else begin
                    idx_nxt   = idx + 8'd1;
                    baddr_nxt = BUF_BASE + 16'(idx + 8'd1);
                    state_nxt = L_FETCH;
                end
            end
            FIN: state_nxt = IDLE;
`ifdef MAP_SS_SUM_EN
            S_SUM:    fin = 1'b1;
            L_SFETCH: state_nxt = L_SCHK;
            L_SCHK: begin
                if (bus.buf_rdat == sum) fin = 1'b1;
                else                     abort = 1'b1;
            end
`endif
            default: state_nxt = IDLE;
        endcase

        if (fin) begin
            state_nxt = FIN;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            act_nxt   = 1'b0;
            we_nxt    = 1'b0;
        end
        if (abort) begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
            err_nxt   = 1'b1;
            act_nxt   = 1'b0;
            we_nxt    = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            cnt          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            bus.ss_act   <= 1'b0;
            bus.ss_we    <= 1'b0;
            bus.ss_addr  <= '0;
            bus.ss_wdat  <= '0;
            bus.buf_addr <= BUF_BASE;
            bus.buf_we   <= 1'b0;
            bus.buf_wdat <= '0;
`ifdef MAP_SS_SUM_EN
            sum          <= '0;
`endif
        end else begin
            state        <= state_nxt;
            idx          <= idx_nxt;
            cnt          <= cnt_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
            err          <= err_nxt;
            bus.ss_act   <= act_nxt;
            bus.ss_we    <= we_nxt;
            bus.ss_addr  <= addr_nxt;
            bus.ss_wdat  <= wdat_nxt;
            bus.buf_addr <= baddr_nxt;
            bus.buf_we   <= bwe_nxt;
            bus.buf_wdat <= bwdat_nxt;
`ifdef MAP_SS_SUM_EN
            sum          <= sum_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_map_ss_seq.sv
// Directed bench for map_ss_seq with a 4-register mapper model and a registered byte buffer.
`timescale 1ns/1ps
module tb_map_ss_seq;
    localparam int          SS   = 4;
    localparam logic [15:0] BASE = 16'h0100;
    localparam int          TMO  = 16;
`ifdef MAP_SS_SUM_EN
    localparam int SAVE_LAT = 10;
    localparam int NBW      = 5;
`else
    localparam int SAVE_LAT = 9;
    localparam int NBW      = 4;
`endif

    logic clk = 1'b0, rst = 1'b1, start_save = 1'b0, start_load = 1'b0, m2_fall = 1'b0;
    logic busy, done, err;

    map_ss_seq_if bus ();

    map_ss_seq #(.SS_REGS(SS), .BUF_BASE(BASE), .M2_TMO(TMO)) dut (
        .clk(clk), .rst(rst), .start_save(start_save), .start_load(start_load),
        .m2_fall(m2_fall), .busy(busy), .done(done), .err(err), .bus(bus)
    );

    always #5 clk = ~clk;

    // Buffer: one-cycle read latency; mapper: latches on an m2 fall only when ss_we was already set up.
    logic [7:0]  mem [0:65535];
    logic [7:0]  map_reg [0:SS-1];
    int          wr_cnt [0:SS-1];
    int          bwr_cnt = 0, bad_cnt = 0;
    logic        we_prev = 1'b0;
    logic        pk_we = 1'b0, mk_we = 1'b0, clr = 1'b0;
    logic [15:0] pk_addr = '0;
    logic [1:0]  mk_addr = '0;
    logic [7:0]  pk_dat = '0, mk_dat = '0;
    int          m2_per = 0, m2_n = 0;
    int          checks = 0, errors = 0;

    assign bus.ss_rdat = map_reg[bus.ss_addr[1:0]];

    always @(posedge clk) begin
        if (pk_we)           mem[pk_addr] <= pk_dat;
        else if (bus.buf_we) mem[bus.buf_addr] <= bus.buf_wdat;
        bus.buf_rdat <= mem[bus.buf_addr];
        if (clr)             bwr_cnt <= 0;
        else if (bus.buf_we) bwr_cnt <= bwr_cnt + 1;
    end

    always @(posedge clk) begin
        we_prev <= bus.ss_we;
        if (clr) begin
            for (int i = 0; i < SS; i++) wr_cnt[i] <= 0;
            bad_cnt <= 0;
        end else if (mk_we) begin
            map_reg[mk_addr] <= mk_dat;
        end else if (m2_fall && bus.ss_act && bus.ss_we && we_prev) begin
            if (bus.ss_addr < 8'(SS)) begin
                map_reg[bus.ss_addr[1:0]] <= bus.ss_wdat;
                wr_cnt[bus.ss_addr[1:0]]  <= wr_cnt[bus.ss_addr[1:0]] + 1;
            end else begin
                bad_cnt <= bad_cnt + 1;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m2_n++;
            m2_fall = (m2_per != 0) && (m2_n % m2_per == 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic mem_poke(input logic [15:0] a, input logic [7:0] d);
        pk_addr = a; pk_dat = d; pk_we = 1'b1;
        @(posedge clk); #1 pk_we = 1'b0;
    endtask

    task automatic map_poke(input int a, input logic [7:0] d);
        mk_addr = 2'(a); mk_dat = d; mk_we = 1'b1;
        @(posedge clk); #1 mk_we = 1'b0;
    endtask

    task automatic clear_counts();
        clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
    endtask

    task automatic start(input logic s, input logic l);
        start_save = s; start_load = l;
        @(posedge clk); #1;
        start_save = 1'b0; start_load = 1'b0;
    endtask

    // Waits (bounded) for done or err; counts cycles from the start edge and ss_act gaps.
    task automatic wait_end(output int lat, output logic d, output logic e,
                            output int gaps, output logic b1);
        lat = 0; d = 1'b0; e = 1'b0; gaps = 0; b1 = 1'b0;
        while (!d && !e && lat < 3000) begin
            @(negedge clk);
            lat++;
            if (lat == 1) b1 = busy;
            d = done; e = err;
            if (!d && !e && !bus.ss_act) gaps++;
        end
    endtask

    typedef struct {
        logic        save;
        logic [31:0] data;
        int          m2_per;
        int          exp_lat;
    } vec_t;

    vec_t       vt [5];
    int         lat, gaps, t, n;
    logic       d, e, b1, found;
    logic [7:0] b, x;

    initial begin
        vt[0] = '{1'b1, 32'h13121110, 0,  SAVE_LAT};
        vt[1] = '{1'b0, 32'hFF003CA5, 12, 0};
        vt[2] = '{1'b1, 32'h08040201, 0,  SAVE_LAT};
        vt[3] = '{1'b0, 32'h8001AA55, 3,  0};
        vt[4] = '{1'b0, 32'h77665544, 1,  0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_ss_act", bus.ss_act, 0);
        check("rst_ss_we", bus.ss_we, 0);
        check("rst_ss_addr", bus.ss_addr, 0);
        check("rst_ss_wdat", bus.ss_wdat, 0);
        check("rst_buf_addr", bus.buf_addr, BASE);
        check("rst_buf_we", bus.buf_we, 0);
        check("rst_buf_wdat", bus.buf_wdat, 0);
        rst = 1'b0;

        for (int r = 0; r < 5; r++) begin
            m2_per = vt[r].m2_per;
            x = 8'h00;
            for (int i = 0; i < SS; i++) begin
                b = vt[r].data[8*i +: 8];
                x = x ^ b;
                if (vt[r].save) begin
                    map_poke(i, b);
                    mem_poke(16'(BASE + i), 8'hEE);
                end else begin
                    map_poke(i, 8'hEE);
                    mem_poke(16'(BASE + i), b);
                end
            end
            mem_poke(16'(BASE + SS), vt[r].save ? 8'hEE : x);
            clear_counts();
            start(vt[r].save, !vt[r].save);
            wait_end(lat, d, e, gaps, b1);
            check($sformatf("r%0d_done", r), d, 1);
            check($sformatf("r%0d_err", r), e, 0);
            check($sformatf("r%0d_busy_first", r), b1, 1);
            check($sformatf("r%0d_act_gaps", r), gaps, 0);
            if (vt[r].exp_lat != 0) check($sformatf("r%0d_latency", r), lat, vt[r].exp_lat);
            @(negedge clk);
            check($sformatf("r%0d_busy_after", r), busy, 0);
            check($sformatf("r%0d_act_after", r), bus.ss_act, 0);
            check($sformatf("r%0d_done_pulse", r), done, 0);
            for (int i = 0; i < SS; i++) begin
                b = vt[r].data[8*i +: 8];
                if (vt[r].save) begin
                    check($sformatf("r%0d_buf%0d", r, i), mem[16'(BASE + i)], b);
                end else begin
                    check($sformatf("r%0d_map%0d", r, i), map_reg[i], b);
                    check($sformatf("r%0d_wrcnt%0d", r, i), wr_cnt[i], 1);
                end
            end
            check($sformatf("r%0d_buf_writes", r), bwr_cnt, vt[r].save ? NBW : 0);
            check($sformatf("r%0d_bad_addr", r), bad_cnt, 0);
        end

        // m2 never falls: abort 17 cycles after L_WRITE entry.
        m2_per = 0;
        for (int i = 0; i < SS; i++) mem_poke(16'(BASE + i), 8'(8'h30 + i));
        clear_counts();
        start(1'b0, 1'b1);
        n = 0; found = 1'b0;
        while (!found && n < 100) begin
            @(negedge clk); n++;
            found = bus.ss_we;
        end
        check("tmo_we_seen", found, 1);
        t = 0;
        while (!err && !done && t < 100) begin
            @(negedge clk); t++;
        end
        check("tmo_latency", t, 17);
        check("tmo_err", err, 1);
        check("tmo_no_done", done, 0);
        check("tmo_we_low", bus.ss_we, 0);
        check("tmo_act_low", bus.ss_act, 0);
        check("tmo_busy_low", busy, 0);
        @(negedge clk);
        check("tmo_err_pulse", err, 0);
        check("tmo_no_write", wr_cnt[0], 0);

        // Simultaneous starts: save wins; a load pulse mid-save is ignored.
        for (int i = 0; i < SS; i++) begin
            map_poke(i, 8'(8'h2D + 8'h0F * i));
            mem_poke(16'(BASE + i), 8'hEE);
        end
        clear_counts();
        start(1'b1, 1'b1);
        repeat (3) @(negedge clk);
        start(1'b0, 1'b1);
        wait_end(lat, d, e, gaps, b1);
        check("both_done", d, 1);
        check("both_err", e, 0);
        for (int i = 0; i < SS; i++)
            check($sformatf("both_buf%0d", i), mem[16'(BASE + i)], 8'(8'h2D + 8'h0F * i));
        check("both_buf_writes", bwr_cnt, NBW);
        repeat (3) @(negedge clk);
        check("both_idle_after", busy, 0);

        // Reset while index 2 is in L_WRITE, then a clean save.
        for (int i = 0; i < SS; i++) begin
            map_poke(i, 8'hEE);
            mem_poke(16'(BASE + i), 8'(8'h11 * (i + 1)));
        end
        clear_counts();
        m2_per = 12;
        start(1'b0, 1'b1);
        n = 0; found = 1'b0;
        while (!found && n < 500) begin
            @(negedge clk); n++;
            found = bus.ss_we && (bus.ss_addr == 8'd2);
        end
        check("rst_mid_found", found, 1);
        rst = 1'b1;
        #1;
        check("rst_mid_act", bus.ss_act, 0);
        check("rst_mid_we", bus.ss_we, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_buf_addr", bus.buf_addr, BASE);
        check("rst_mid_wr0", wr_cnt[0], 1);
        check("rst_mid_wr1", wr_cnt[1], 1);
        check("rst_mid_map1", map_reg[1], 8'h22);
        @(negedge clk);
        rst = 1'b0;
        m2_per = 0;
        for (int i = 0; i < SS; i++) map_poke(i, 8'(8'hC0 + i));
        clear_counts();
        start(1'b1, 1'b0);
        wait_end(lat, d, e, gaps, b1);
        check("post_rst_done", d, 1);
        check("post_rst_latency", lat, SAVE_LAT);
        for (int i = 0; i < SS; i++)
            check($sformatf("post_rst_buf%0d", i), mem[16'(BASE + i)], 8'(8'hC0 + i));

`ifdef MAP_SS_SUM_EN
        // Checksum stored on save; a corrupted checksum makes the load end in err.
        for (int i = 0; i < SS; i++) map_poke(i, 8'(1 << i));
        clear_counts();
        start(1'b1, 1'b0);
        wait_end(lat, d, e, gaps, b1);
        check("sum_save_done", d, 1);
        check("sum_byte", mem[16'(BASE + SS)], 8'h0F);
        mem_poke(16'(BASE + SS), 8'h0E);
        for (int i = 0; i < SS; i++) map_poke(i, 8'hEE);
        clear_counts();
        m2_per = 4;
        start(1'b0, 1'b1);
        wait_end(lat, d, e, gaps, b1);
        check("sum_bad_err", e, 1);
        check("sum_bad_no_done", d, 0);
        check("sum_bad_busy", busy, 0);
        check("sum_bad_act", bus.ss_act, 0);
        for (int i = 0; i < SS; i++)
            check($sformatf("sum_bad_map%0d", i), map_reg[i], 8'(1 << i));
        m2_per = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
